// File: rtl/rca_nibble_seq.sv
// rca_nibble_seq: multi-cycle adder time-sharing one 4-bit ripple slice, LSB nibble first
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [4:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[4];
endmodule

module rca_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic [IW-1:0] idx;
  logic [3:0] s_nib;
  logic carry, co, last;
  rca_4 u_slice (.a(a_sh[3:0]), .b(b_sh[3:0]), .c_in(carry), .sum(s_nib), .c_out(co));
  assign last   = idx == IW'(NIBBLES - 1);
  assign acc_nx = {s_nib, acc[WIDTH-1:4]};
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nx;
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      carry <= co;
      idx   <= idx + 1'b1;
      if (last) begin
        sum   <= acc_nx;
        c_out <= co;
        ovf   <= (a_sh[3] == b_sh[3]) && (s_nib[3] != a_sh[3]);
      end
    end
  end
endmodule
